// File: rtl/vblank_access_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : vblank_access_scheduler_if
// Brief    : Requester-side handshake bundle for the blanking-window RAM
//            port scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface vblank_access_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] gnt;
    logic [2:0]         gnt_id;
    logic [NUM_REQ-1:0] abort;

    modport master (output req, done, input gnt, gnt_id, abort);
    modport slave  (input req, done, output gnt, gnt_id, abort);
endinterface
`default_nettype wire

// File: rtl/vblank_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vblank_access_scheduler
// Brief    : Round-robin, once-per-frame access scheduler for the shared
//            sprite/attribute RAM during vertical blanking. Optional
//            missed-request capture is built when VBLANK_SCHED_STATS_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module vblank_access_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int HL_TOTAL_TIME    = 1344,
    parameter int VL_BLANK_START   = 768,
    parameter int VL_TOTAL_TIME    = 806,
    parameter int GUARD_LINES      = 2,
    parameter int MAX_GRANT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [10:0]               vcount,
    input  logic [10:0]               hcount,
    vblank_access_scheduler_if.slave  bus,
    output logic                      window_open,
    output logic                      frame_start,
    output logic                      timeout,
    output logic [NUM_REQ-1:0]        missed_mask
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w = (MAX_GRANT_CYCLES > 1) ? $clog2(MAX_GRANT_CYCLES) : 1;

    localparam logic [10:0]        c_open_line   = 11'(VL_BLANK_START);
    localparam logic [10:0]        c_close_line  = 11'(VL_TOTAL_TIME - GUARD_LINES);
    localparam logic [10:0]        c_hl_total    = 11'(HL_TOTAL_TIME);
    localparam logic [10:0]        c_vl_total    = 11'(VL_TOTAL_TIME);
    localparam logic [c_cnt_w-1:0] c_budget_init = c_cnt_w'(MAX_GRANT_CYCLES - 1);
    localparam logic [c_ptr_w-1:0] c_last_idx    = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_ptr_w:0]   c_num_req     = (c_ptr_w + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_ARB    = 2'd1,
        ST_GRANT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [c_ptr_w-1:0]  r_gnt_idx;
    logic [NUM_REQ-1:0]  r_served;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_abort;
    logic [c_cnt_w-1:0]  r_budget;
    logic                r_window_open;
    logic                r_frame_start;
    logic                r_timeout;

    logic                w_pos_ok;
    logic                w_open_hit;
    logic                w_close_hit;
    logic                w_found;
    logic [c_ptr_w-1:0]  w_pick;
    logic [c_ptr_w:0]    w_sum;
    logic [NUM_REQ-1:0]  w_pick_oh;
    logic                w_release;

    // Positions outside the raster never trigger window events.
    assign w_pos_ok    = (hcount < c_hl_total) && (vcount < c_vl_total);
    assign w_open_hit  = w_pos_ok && (vcount == c_open_line)  && (hcount == 11'd0);
    assign w_close_hit = w_pos_ok && (vcount == c_close_line) && (hcount == 11'd0);

    // Scan from highest to lowest distance so the nearest candidate wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (c_ptr_w + 1)'(i);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (bus.req[w_sum[c_ptr_w-1:0]] && !r_served[w_sum[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_ptr_w-1:0];
            end
        end
    end

    assign w_pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
    // Dropping req while granted is a release just like done.
    assign w_release = bus.done[r_gnt_idx] || !bus.req[r_gnt_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_CLOSED;
            r_rr_ptr      <= '0;
            r_gnt_idx     <= '0;
            r_served      <= '0;
            r_gnt         <= '0;
            r_abort       <= '0;
            r_budget      <= '0;
            r_window_open <= 1'b0;
            r_frame_start <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_frame_start <= w_open_hit;
            r_abort       <= '0;

            if (w_open_hit) begin
                r_window_open <= 1'b1;
                r_served      <= '0;
                r_timeout     <= 1'b0;
                r_rr_ptr      <= (r_rr_ptr == c_last_idx) ? '0 : r_rr_ptr + 1'b1;
            end else if (w_close_hit) begin
                r_window_open <= 1'b0;
            end

            case (r_state)
                ST_CLOSED: begin
                    if (w_open_hit) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (w_close_hit) begin
                        r_state <= ST_CLOSED;
                    end else if (w_found) begin
                        r_gnt            <= w_pick_oh;
                        r_gnt_idx        <= w_pick;
                        r_served[w_pick] <= 1'b1;
                        r_budget         <= c_budget_init;
                        r_state          <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A release coinciding with close or expiry stays clean.
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_state <= w_close_hit ? ST_CLOSED : ST_ARB;
                    end else if (w_close_hit) begin
                        r_abort <= r_gnt;
                        r_gnt   <= '0;
                        r_state <= ST_CLOSED;
                        if (r_budget == '0) begin
                            r_timeout <= 1'b1;
                        end
                    end else if (r_budget == '0) begin
                        r_timeout <= 1'b1;
                        r_abort   <= r_gnt;
                        r_gnt     <= '0;
                        r_state   <= ST_ARB;
                    end else begin
                        r_budget <= r_budget - 1'b1;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_CLOSED;
                end
            endcase
        end
    end

`ifdef VBLANK_SCHED_STATS_EN
    logic [NUM_REQ-1:0] r_missed;

    // Sampled before the close abort lands, so a revoked grant counts as served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_missed <= '0;
        end else if (w_close_hit && r_window_open) begin
            r_missed <= bus.req & ~r_served;
        end
    end

    assign missed_mask = r_missed;
`else
    assign missed_mask = '0;
`endif

    assign bus.gnt     = r_gnt;
    assign bus.gnt_id  = 3'(r_gnt_idx);
    assign bus.abort   = r_abort;
    assign window_open = r_window_open;
    assign frame_start = r_frame_start;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_vblank_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vblank_access_scheduler
// Brief    : Self-checking bench for vblank_access_scheduler on a raster with
//            a shortened line length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vblank_access_scheduler;

    localparam int NR      = 4;
    localparam int HL      = 32;
    localparam int VL      = 806;
    localparam int VB      = 768;
    localparam int GL      = 2;
    localparam int MAXG    = 16;
    localparam int CLOSE_L = VL - GL;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [10:0]     vcount;
    logic [10:0]     hcount;
    logic            window_open;
    logic            frame_start;
    logic            timeout;
    logic [NR-1:0]   missed_mask;

    vblank_access_scheduler_if #(.NUM_REQ(NR)) bus ();

    vblank_access_scheduler #(
        .NUM_REQ          (NR),
        .HL_TOTAL_TIME    (HL),
        .VL_BLANK_START   (VB),
        .VL_TOTAL_TIME    (VL),
        .GUARD_LINES      (GL),
        .MAX_GRANT_CYCLES (MAXG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vcount      (vcount),
        .hcount      (hcount),
        .bus         (bus),
        .window_open (window_open),
        .frame_start (frame_start),
        .timeout     (timeout),
        .missed_mask (missed_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] req;
        int            n;
        int            order [4];
    } frame_vec_t;

    frame_vec_t    tbl [6];
    int            n_vec = 0;
    int            n_err = 0;
    int            rv, rh;
    int            exp_q [$];
    logic [NR-1:0] hog;
    logic [NR-1:0] prev_gnt;
    logic          prev_wo;
    int            dcnt, did;
    int            fs_cnt, fs_pos, rise_pos, fall_pos;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [NR-1:0] r, input int n,
                           input int o0, input int o1, input int o2, input int o3);
        tbl[idx].req      = r;
        tbl[idx].n        = n;
        tbl[idx].order[0] = o0;
        tbl[idx].order[1] = o1;
        tbl[idx].order[2] = o2;
        tbl[idx].order[3] = o3;
    endtask

    task automatic seek(input int v, input int h);
        rv     = v;
        rh     = h;
        vcount = 11'(rv);
        hcount = 11'(rh);
    endtask

    // One clock: observe registered outputs, run the requester model and
    // scoreboard, then present the next raster position.
    task automatic step();
        int spos;
        int gid;
        @(posedge clk);
        #1;
        spos = rv * HL + rh;
        if (frame_start === 1'b1) begin
            fs_cnt++;
            fs_pos = spos;
        end
        if (window_open === 1'b1 && prev_wo !== 1'b1) rise_pos = spos;
        if (window_open === 1'b0 && prev_wo === 1'b1) fall_pos = spos;
        prev_wo  = window_open;
        bus.done = '0;
        if (bus.gnt != '0 && prev_gnt == '0) begin
            gid = int'(bus.gnt_id);
            if (exp_q.size() == 0) chk("unexpected_grant", 32'(bus.gnt), 32'd0);
            else                   chk("grant_order", 32'(gid), 32'(exp_q.pop_front()));
            chk("grant_onehot", 32'(bus.gnt), 32'd1 << gid);
            if (gid < NR && !hog[gid]) begin
                dcnt = 10;
                did  = gid;
            end else begin
                dcnt = 0;
            end
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) bus.done[did] = 1'b1;
        end
        prev_gnt = bus.gnt;
        rh++;
        if (rh == HL) begin
            rh = 0;
            rv++;
            if (rv == VL) rv = 0;
        end
        vcount = 11'(rv);
        hcount = 11'(rh);
    endtask

    task automatic run_to(input int v, input int h);
        int k;
        k = 0;
        while (!(rv == v && rh == h) && k < VL * HL) begin
            step();
            k++;
        end
        chk("run_to_bound", 32'(rv == v && rh == h), 32'd1);
    endtask

    initial begin
        int bad;
        int k;
        int cnt;
        int nsteps;

        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        hog      = '0;
        dcnt     = 0;
        did      = 0;
        prev_gnt = '0;
        prev_wo  = 1'b0;
        fs_cnt   = 0;
        fs_pos   = -1;
        rise_pos = -1;
        fall_pos = -1;

        set_vec(0, 4'b1111, 4, 1, 2, 3, 0);
        set_vec(1, 4'b1111, 4, 2, 3, 0, 1);
        set_vec(2, 4'b0101, 2, 0, 2, 0, 0);
        set_vec(3, 4'b1010, 2, 1, 3, 0, 0);
        set_vec(4, 4'b0000, 0, 0, 0, 0, 0);
        set_vec(5, 4'b1001, 2, 3, 0, 0, 0);

        // Reset in the middle of the blanking window.
        seek(770, 5);
        repeat (3) step();
        chk("rst_gnt",         32'(bus.gnt),     32'd0);
        chk("rst_gnt_id",      32'(bus.gnt_id),  32'd0);
        chk("rst_window_open", 32'(window_open), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_abort",       32'(bus.abort),   32'd0);
        chk("rst_timeout",     32'(timeout),     32'd0);
        chk("rst_missed",      32'(missed_mask), 32'd0);

        rst_n   = 1'b1;
        bus.req = 4'b1111;
        bad     = 0;
        k       = 0;
        while (!(rv == VB - 1 && rh == HL - 4) && k < VL * HL) begin
            step();
            if (bus.gnt !== '0 || window_open !== 1'b0) bad++;
            k++;
        end
        chk("no_grant_before_open", 32'(bad), 32'd0);
        chk("no_open_after_reset", 32'(fs_cnt), 32'd0);

        // Table: each record is one window with its expected grant order.
        for (int e = 0; e < 6; e++) begin
            bus.req = tbl[e].req;
            hog     = '0;
            for (int j = 0; j < tbl[e].n; j++) exp_q.push_back(tbl[e].order[j]);
            if (e > 0) seek(VB - 1, HL - 4);
            fs_cnt = 0;
            nsteps = (e == 0) ? VL * HL : (CLOSE_L + 1 - (VB - 1)) * HL;
            repeat (nsteps) step();
            chk("frame_start_count", 32'(fs_cnt), 32'd1);
            if (e == 0) begin
                chk("window_rise", 32'(rise_pos), 32'(VB * HL));
                chk("window_fall", 32'(fall_pos), 32'(CLOSE_L * HL));
                chk("frame_start_pos", 32'(fs_pos), 32'(VB * HL));
            end
            chk("grants_left", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            chk("missed_clean", 32'(missed_mask), 32'd0);
        end

        // Budget expiry: requester 0 never releases.
        bus.req = 4'b0011;
        hog     = 4'b0001;
        exp_q.push_back(0);
        exp_q.push_back(1);
        seek(VB - 1, HL - 4);
        k = 0;
        while (bus.gnt == '0 && k < 200) begin
            step();
            k++;
        end
        chk("bud_first_gnt", 32'(bus.gnt), 32'h1);
        cnt = 0;
        while (bus.gnt == 4'b0001 && cnt < 100) begin
            cnt++;
            step();
        end
        chk("bud_grant_len", 32'(cnt), 32'(MAXG));
        chk("bud_abort",     32'(bus.abort), 32'h1);
        chk("bud_timeout",   32'(timeout),   32'd1);
        chk("bud_gnt_drop",  32'(bus.gnt),   32'd0);
        step();
        chk("bud_next_gnt",  32'(bus.gnt),   32'h2);
        chk("bud_abort_pulse", 32'(bus.abort), 32'd0);
        run_to(CLOSE_L + 1, 0);
        chk("bud_timeout_sticky", 32'(timeout), 32'd1);
        chk("bud_grants_left", 32'(exp_q.size()), 32'd0);

        // Close while requester 2 holds the port.
        bus.req = '0;
        hog     = 4'b0100;
        seek(VB - 1, HL - 4);
        k = 0;
        while (frame_start !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk("close_frame_start", 32'(frame_start), 32'd1);
        chk("timeout_cleared",   32'(timeout),     32'd0);
        run_to(CLOSE_L - 1, 20);
        bus.req = 4'b0100;
        exp_q.push_back(2);
        step();
        chk("close_gnt", 32'(bus.gnt), 32'h4);
        run_to(CLOSE_L, 0);
        chk("close_gnt_held", 32'(bus.gnt), 32'h4);
        step();
        chk("close_abort",    32'(bus.abort),   32'h4);
        chk("close_gnt_drop", 32'(bus.gnt),     32'd0);
        chk("close_window",   32'(window_open), 32'd0);
        chk("close_missed",   32'(missed_mask), 32'd0);
        step();
        chk("close_abort_pulse", 32'(bus.abort), 32'd0);
        run_to(CLOSE_L + 1, 0);
        chk("close_no_regrant", 32'(bus.gnt), 32'd0);
        chk("close_grants_left", 32'(exp_q.size()), 32'd0);

        // Requester 3 waits behind requester 0 until close.
        bus.req = '0;
        hog     = 4'b0001;
        seek(VB - 1, HL - 4);
        run_to(CLOSE_L - 1, 20);
        bus.req[0] = 1'b1;
        exp_q.push_back(0);
        run_to(CLOSE_L - 1, 25);
        bus.req[3] = 1'b1;
        chk("stats_gnt0", 32'(bus.gnt), 32'h1);
        run_to(CLOSE_L, 0);
        step();
        chk("stats_abort", 32'(bus.abort), 32'h1);
`ifdef VBLANK_SCHED_STATS_EN
        chk("stats_missed", 32'(missed_mask), 32'h8);
        run_to(CLOSE_L + 1, 0);
        chk("stats_missed_hold", 32'(missed_mask), 32'h8);
`else
        chk("stats_missed", 32'(missed_mask), 32'h0);
        run_to(CLOSE_L + 1, 0);
        chk("stats_missed_hold", 32'(missed_mask), 32'h0);
`endif
        chk("stats_grants_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
